johnson_step_ctrl: RTL and testbench

Command-driven sequencer for an N-bit Johnson phase register. It steps the register through its 2N-state sequence a programmed number of times, in a programmed direction, at a programmed rate. It sits between a host or command FSM and a multi-phase load such as stepper windings or a phased enable fan-out. The phase position persists across commands, and only reset clears it.

---
 rtl/johnson_step_ctrl.sv | 105 ++++++++++
 tb/tb_johnson_step_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_step_ctrl.sv
// Command-driven sequencer for an N-bit Johnson phase register: steps the
// phase a programmed number of times, in a programmed direction and rate.
module johnson_step_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 16,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             cmd_dir,
   input  logic [DIV_W-1:0] cmd_div,
   input  logic             abort,
   output logic [N-1:0]     phase,
   output logic             step_pulse,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic             dir_r;
   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] div_cnt;

   // Legal Johnson codes are a run of ones anchored at bit 0, or its complement.
   function automatic logic is_johnson(input logic [N-1:0] p);
      logic [N-1:0] q;
      q = ~p;
      return ((p & (p + 1'b1)) == '0) || ((q & (q + 1'b1)) == '0);
   endfunction

   function automatic logic [N-1:0] next_phase(input logic [N-1:0] p, input logic rev);
      if (!is_johnson(p))
         return '0;
      else if (rev)
         return {~p[0], p[N-1:1]};
      else
         return {p[N-2:0], ~p[N-1]};
   endfunction

   // A divide ratio of 0 behaves as 1, so both reload the counter with 0.
   function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   assign cmd_ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         steps_left <= '0;
         step_pulse <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dir_r      <= 1'b0;
         div_r      <= '0;
         div_cnt    <= '0;
      end else begin
         step_pulse <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  dir_r      <= cmd_dir;
                  div_r      <= cmd_div;
                  div_cnt    <= reload(cmd_div);
                  steps_left <= cmd_steps;
                  if (cmd_steps == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (div_cnt == '0) begin
                  phase      <= next_phase(phase, dir_r);
                  step_pulse <= 1'b1;
                  div_cnt    <= reload(div_r);
                  steps_left <= steps_left - 1'b1;
                  if (steps_left == CNT_W'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Scoreboard bench for johnson_step_ctrl: directed commands push expected
// step/done events; a monitor pops and compares them as the DUT reports.
module tb_johnson_step_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_steps;
   logic        cmd_dir;
   logic [15:0] cmd_div;
   logic        abort;
   logic [3:0]  phase;
   logic        step_pulse;
   logic        busy;
   logic        done;
   logic [15:0] steps_left;

   johnson_step_ctrl #(.N(4), .CNT_W(16), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_div(cmd_div), .abort(abort),
      .phase(phase), .step_pulse(step_pulse), .busy(busy), .done(done),
      .steps_left(steps_left)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [3:0]  ph;
      logic [15:0] left;
      logic        pulse;
      logic        dn;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acc = 0;
   int   busy_total = 0;
   int   pulse_total = 0;
   int   done_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (busy) busy_total++;
         if (step_pulse) pulse_total++;
         if (done) done_total++;
         if (step_pulse || done) begin
            if (q.size() == 0) begin
               chk("unexpected_event", {30'd0, step_pulse, done}, 32'd0);
            end else begin
               e = q.pop_front();
               chk("event_cycle", cyc, e.cyc);
               chk("event_phase", {28'd0, phase}, {28'd0, e.ph});
               chk("event_steps_left", {16'd0, steps_left}, {16'd0, e.left});
               chk("event_step_pulse", {31'd0, step_pulse}, {31'd0, e.pulse});
               chk("event_done", {31'd0, done}, {31'd0, e.dn});
            end
         end
      end
   end

   // Called at a negedge: wait for cmd_ready, present the command.
   task automatic start(input logic [15:0] s, input logic d, input logic [15:0] dv);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b1;
      cmd_steps = s;
      cmd_dir   = d;
      cmd_div   = dv;
      acc       = cyc + 1;
   endtask

   task automatic expect_ev(input int off, input logic [3:0] ph, input logic [15:0] left,
                            input logic pulse, input logic dn);
      exp_t e;
      e.cyc = acc + off; e.ph = ph; e.left = left; e.pulse = pulse; e.dn = dn;
      q.push_back(e);
   endtask

   task automatic go();
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready && n < 500);
      if (!cmd_ready) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   int b0, p0, d0, acc1;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_div = '0; abort = 1'b0;
      #12 rst = 1'b0;
      @(negedge clk);
      chk("rst_phase", {28'd0, phase}, 32'd0);
      chk("rst_steps_left", {16'd0, steps_left}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // 8 forward steps at full rate: full cycle back to 0000
      b0 = busy_total; p0 = pulse_total; d0 = done_total;
      start(16'd8, 1'b0, 16'd1);
      expect_ev(1, 4'b0001, 16'd7, 1, 0);
      expect_ev(2, 4'b0011, 16'd6, 1, 0);
      expect_ev(3, 4'b0111, 16'd5, 1, 0);
      expect_ev(4, 4'b1111, 16'd4, 1, 0);
      expect_ev(5, 4'b1110, 16'd3, 1, 0);
      expect_ev(6, 4'b1100, 16'd2, 1, 0);
      expect_ev(7, 4'b1000, 16'd1, 1, 0);
      expect_ev(8, 4'b0000, 16'd0, 1, 1);
      go();
      wait_idle();
      chk("t1_busy_cycles", busy_total - b0, 32'd8);
      chk("t1_pulses", pulse_total - p0, 32'd8);
      chk("t1_dones", done_total - d0, 32'd1);
      chk("t1_steps_left", {16'd0, steps_left}, 32'd0);

      // reverse 3 then back-to-back forward 3
      start(16'd3, 1'b1, 16'd1);
      expect_ev(1, 4'b1000, 16'd2, 1, 0);
      expect_ev(2, 4'b1100, 16'd1, 1, 0);
      expect_ev(3, 4'b1110, 16'd0, 1, 1);
      go();
      acc1 = acc;
      wait_idle();
      start(16'd3, 1'b0, 16'd1);
      chk("t2_back_to_back_accept", acc, acc1 + 4);
      expect_ev(1, 4'b1100, 16'd2, 1, 0);
      expect_ev(2, 4'b1000, 16'd1, 1, 0);
      expect_ev(3, 4'b0000, 16'd0, 1, 1);
      go();
      wait_idle();

      // divide by 4
      b0 = busy_total;
      start(16'd2, 1'b0, 16'd4);
      expect_ev(4, 4'b0001, 16'd1, 1, 0);
      expect_ev(8, 4'b0011, 16'd0, 1, 1);
      go();
      wait_idle();
      chk("t3_busy_cycles", busy_total - b0, 32'd8);

      // divide by 0 behaves as 1
      b0 = busy_total;
      start(16'd2, 1'b0, 16'd0);
      expect_ev(1, 4'b0111, 16'd1, 1, 0);
      expect_ev(2, 4'b1111, 16'd0, 1, 1);
      go();
      wait_idle();
      chk("t3_div0_busy_cycles", busy_total - b0, 32'd2);

      // zero-step command: done only
      b0 = busy_total; p0 = pulse_total;
      start(16'd0, 1'b0, 16'd1);
      expect_ev(0, 4'b1111, 16'd0, 0, 1);
      go();
      @(negedge clk);
      chk("t4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("t4_phase", {28'd0, phase}, 32'hf);
      repeat (2) @(negedge clk);
      chk("t4_no_busy", busy_total - b0, 32'd0);
      chk("t4_no_pulse", pulse_total - p0, 32'd0);

      // divide by 3, forward 4: 1111 -> 0000
      start(16'd4, 1'b0, 16'd3);
      expect_ev(3, 4'b1110, 16'd3, 1, 0);
      expect_ev(6, 4'b1100, 16'd2, 1, 0);
      expect_ev(9, 4'b1000, 16'd1, 1, 0);
      expect_ev(12, 4'b0000, 16'd0, 1, 1);
      go();
      wait_idle();

      // abort after the third step
      d0 = done_total; p0 = pulse_total;
      start(16'd10, 1'b0, 16'd1);
      expect_ev(1, 4'b0001, 16'd9, 1, 0);
      expect_ev(2, 4'b0011, 16'd8, 1, 0);
      expect_ev(3, 4'b0111, 16'd7, 1, 0);
      go();
      repeat (3) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("t5_phase", {28'd0, phase}, 32'h7);
      chk("t5_steps_left", {16'd0, steps_left}, 32'd7);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      chk("t5_no_done", done_total - d0, 32'd0);
      chk("t5_pulses", pulse_total - p0, 32'd3);
      start(16'd1, 1'b0, 16'd1);
      expect_ev(1, 4'b1111, 16'd0, 1, 1);
      go();
      wait_idle();

      // return to 0000, then async reset mid-run at 0011
      start(16'd4, 1'b0, 16'd1);
      expect_ev(1, 4'b1110, 16'd3, 1, 0);
      expect_ev(2, 4'b1100, 16'd2, 1, 0);
      expect_ev(3, 4'b1000, 16'd1, 1, 0);
      expect_ev(4, 4'b0000, 16'd0, 1, 1);
      go();
      wait_idle();
      start(16'd5, 1'b0, 16'd2);
      expect_ev(2, 4'b0001, 16'd4, 1, 0);
      expect_ev(4, 4'b0011, 16'd3, 1, 0);
      go();
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t6_rst_phase", {28'd0, phase}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_steps_left", {16'd0, steps_left}, 32'd0);
      chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      #2 rst = 1'b0;
      @(negedge clk);
      start(16'd1, 1'b1, 16'd1);
      expect_ev(1, 4'b1000, 16'd0, 1, 1);
      go();
      wait_idle();

      // illegal phase self-corrects to 0000 on the next step
      force dut.phase = 4'b0101;
      #1 release dut.phase;
      @(negedge clk);
      chk("t7_forced_phase", {28'd0, phase}, 32'h5);
      start(16'd1, 1'b0, 16'd1);
      expect_ev(1, 4'b0000, 16'd0, 1, 1);
      go();
      wait_idle();
      repeat (3) @(negedge clk);

      chk("queue_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
